// File: rtl/audio_pwm_out.sv
// Audio output stage: turns the 8-bit sample stream into a 256-cycle-frame PWM bit,
// with a mute/ramp state machine that fades in and out to avoid clicks.
module audio_pwm_out (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       div_clk,
    input  logic [7:0] wav,
    input  logic       clr_ovr,
    output logic       pwm_out,
    output logic       amp_en,
    output logic [1:0] state,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t     st;
    logic       div_q;
    logic       strobe;
    logic       boundary;
    logic [7:0] fcnt;
    logic [7:0] duty;
    logic [7:0] level;
    logic [7:0] pend;
    logic       pend_valid;

    assign strobe   = div_clk & ~div_q;
    assign boundary = (fcnt == 8'd255);
    assign state    = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            div_q      <= 1'b0;
            fcnt       <= 8'd0;
            duty       <= 8'd0;
            level      <= 8'd0;
            pend       <= 8'h80;
            pend_valid <= 1'b0;
            pwm_out    <= 1'b0;
            amp_en     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            div_q   <= div_clk;
            fcnt    <= fcnt + 8'd1;
            pwm_out <= (fcnt < duty);

            // A boundary strobe is consumed by the next frame, so it never counts as lost.
            if (strobe && pend_valid && (st == PLAY) && !boundary)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;

            if (boundary) begin
                case (st)
                    IDLE: begin
                        duty <= 8'd0;
                        if (en) begin
                            st     <= RAMP_UP;
                            level  <= 8'd0;
                            amp_en <= 1'b1;
                        end
                    end
                    RAMP_UP: begin
                        if (!en) begin
                            st <= RAMP_DOWN;
                        end else if (level == 8'h80) begin
                            st         <= PLAY;
                            duty       <= pend;
                            pend_valid <= 1'b0;
                        end else if (level < 8'h80) begin
                            level <= level + 8'd1;
                            duty  <= level + 8'd1;
                        end else begin
                            level <= level - 8'd1;
                            duty  <= level - 8'd1;
                        end
                    end
                    PLAY: begin
                        if (en) begin
                            duty       <= pend;
                            pend_valid <= 1'b0;
                        end else begin
                            st    <= RAMP_DOWN;
                            level <= duty;
                        end
                    end
                    RAMP_DOWN: begin
                        if (en) begin
                            st <= RAMP_UP;
                        end else if (level == 8'd0) begin
                            st     <= IDLE;
                            duty   <= 8'd0;
                            amp_en <= 1'b0;
                        end else begin
                            level <= level - 8'd1;
                            duty  <= level - 8'd1;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end

            // Placed last so a capture on the boundary leaves pend_valid set.
            if (strobe) begin
                pend       <= wav;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: reset, fade-in, duty extremes, overrun,
// fade-out and mid-operation events, each as its own task.
module tb_audio_pwm_out;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_clk;
    logic [7:0] wav;
    logic       clr_ovr;
    logic       pwm_out;
    logic       amp_en;
    logic [1:0] state;
    logic       overrun;

    logic [7:0] mf;
    int         total = 0;
    int         bad   = 0;

    audio_pwm_out dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_clk (div_clk),
        .wav     (wav),
        .clr_ovr (clr_ovr),
        .pwm_out (pwm_out),
        .amp_en  (amp_en),
        .state   (state),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Bench-side frame position: value the DUT frame counter holds after each edge.
    always @(posedge clk) begin
        if (rst) mf <= 8'd0;
        else     mf <= mf + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the boundary edge has just passed.
    task automatic next_frame();
        do tick(); while (mf != 8'd0);
    endtask

    // Count high PWM cycles up to and including the next boundary edge.
    task automatic count_to_boundary(output int hi, output logic last);
        hi = 0;
        last = 1'b0;
        do begin
            tick();
            if (pwm_out) hi++;
            last = pwm_out;
        end while (mf != 8'd0);
    endtask

    task automatic send(input logic [7:0] v);
        wav     = v;
        div_clk = 1'b1;
        tick();
        div_clk = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; div_clk = 1'b0; wav = 8'h80; clr_ovr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            div_clk = ~div_clk;
            tick();
        end
        total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
        total++; if (amp_en !== 1'b0) begin bad++; $display("FAIL reset_amp_en got=%b exp=0", amp_en); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (dut.pend !== 8'h80) begin bad++; $display("FAIL reset_pend got=%h exp=80", dut.pend); end
        total++; if (dut.pend_valid !== 1'b0) begin bad++; $display("FAIL reset_pend_valid got=%b exp=0", dut.pend_valid); end
        div_clk = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fade_in();
        int   hi;
        logic last;
        logic [7:0] exp_l;
        en = 1'b1;
        next_frame();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL fadein_enter got=%0d exp=1", state); end
        total++; if (amp_en !== 1'b1) begin bad++; $display("FAIL fadein_amp_en got=%b exp=1", amp_en); end
        total++; if (dut.level !== 8'd0) begin bad++; $display("FAIL fadein_level0 got=%h exp=00", dut.level); end
        for (int b = 2; b <= 129; b++) begin
            next_frame();
            exp_l = 8'(b - 1);
            total++;
            if (dut.level !== exp_l || state !== 2'd1) begin
                bad++;
                $display("FAIL fadein_step b=%0d level=%h exp=%h state=%0d exp=1", b, dut.level, exp_l, state);
            end
        end
        next_frame();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL fadein_play got=%0d exp=2", state); end
        count_to_boundary(hi, last);
        total++; if (hi !== 128) begin bad++; $display("FAIL fadein_duty got=%0d exp=128", hi); end
    endtask

    task automatic test_duty_extremes();
        int   hi;
        logic last;
        send(8'h00);
        next_frame();
        count_to_boundary(hi, last);
        total++; if (hi !== 0) begin bad++; $display("FAIL duty_00 got=%0d exp=0", hi); end
        send(8'hFF);
        next_frame();
        count_to_boundary(hi, last);
        total++; if (hi !== 255) begin bad++; $display("FAIL duty_ff got=%0d exp=255", hi); end
        total++; if (last !== 1'b0) begin bad++; $display("FAIL duty_ff_last got=%b exp=0", last); end
        send(8'h40);
        next_frame();
        count_to_boundary(hi, last);
        total++; if (hi !== 64) begin bad++; $display("FAIL duty_40 got=%0d exp=64", hi); end
    endtask

    task automatic test_overrun();
        int   hi;
        logic last;
        send(8'h10);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_single got=%b exp=0", overrun); end
        send(8'h30);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_double got=%b exp=1", overrun); end
        next_frame();
        count_to_boundary(hi, last);
        total++; if (hi !== 48) begin bad++; $display("FAIL ovr_second_played got=%0d exp=48", hi); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        // One sample mid-frame, the next exactly on the boundary edge.
        send(8'h50);
        while (mf != 8'd255) tick();
        send(8'h70);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_boundary got=%b exp=0", overrun); end
        total++; if (dut.pend_valid !== 1'b1) begin bad++; $display("FAIL ovr_boundary_valid got=%b exp=1", dut.pend_valid); end
        count_to_boundary(hi, last);
        total++; if (hi !== 79) begin bad++; $display("FAIL ovr_boundary_old got=%0d exp=79", hi); end
        count_to_boundary(hi, last);
        total++; if (hi !== 112) begin bad++; $display("FAIL ovr_boundary_new got=%0d exp=112", hi); end
        send(8'h20);
        wav     = 8'h22;
        div_clk = 1'b1;
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        div_clk = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear2 got=%b exp=0", overrun); end
    endtask

    task automatic test_fade_out();
        int   hi;
        logic last;
        logic [7:0] exp_d;
        next_frame();
        send(8'h40);
        next_frame();
        en = 1'b0;
        count_to_boundary(hi, last);
        total++; if (hi !== 64) begin bad++; $display("FAIL fadeout_last_play got=%0d exp=64", hi); end
        total++; if (state !== 2'd3) begin bad++; $display("FAIL fadeout_enter got=%0d exp=3", state); end
        total++; if (dut.level !== 8'h40) begin bad++; $display("FAIL fadeout_level got=%h exp=40", dut.level); end
        total++; if (amp_en !== 1'b1) begin bad++; $display("FAIL fadeout_amp_on got=%b exp=1", amp_en); end
        send(8'h11);
        send(8'h12);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fadeout_no_ovr got=%b exp=0", overrun); end
        count_to_boundary(hi, last);
        total++; if (hi !== 60) begin bad++; $display("FAIL fadeout_first got=%0d exp=60", hi); end
        total++; if (dut.duty !== 8'h3F) begin bad++; $display("FAIL fadeout_duty1 got=%h exp=3f", dut.duty); end
        for (int k = 2; k <= 64; k++) begin
            count_to_boundary(hi, last);
            exp_d = 8'(64 - k);
            total++;
            if (hi !== 65 - k || dut.duty !== exp_d || state !== 2'd3) begin
                bad++;
                $display("FAIL fadeout_step k=%0d hi=%0d exp=%0d duty=%h exp=%h state=%0d", k, hi, 65 - k, dut.duty, exp_d, state);
            end
        end
        count_to_boundary(hi, last);
        total++; if (hi !== 0) begin bad++; $display("FAIL fadeout_zero got=%0d exp=0", hi); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL fadeout_idle got=%0d exp=0", state); end
        total++; if (amp_en !== 1'b0) begin bad++; $display("FAIL fadeout_amp_off got=%b exp=0", amp_en); end
    endtask

    task automatic test_mid_events();
        en = 1'b1;
        next_frame();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL mid_rampup got=%0d exp=1", state); end
        for (int i = 0; i < 33; i++) next_frame();
        total++; if (dut.level !== 8'h21) begin bad++; $display("FAIL mid_level21 got=%h exp=21", dut.level); end
        en = 1'b0;
        next_frame();
        total++; if (state !== 2'd3 || dut.level !== 8'h21) begin bad++; $display("FAIL mid_down_hold state=%0d level=%h exp=3/21", state, dut.level); end
        next_frame();
        total++; if (dut.level !== 8'h20) begin bad++; $display("FAIL mid_down_level got=%h exp=20", dut.level); end
        en = 1'b1;
        next_frame();
        total++; if (state !== 2'd1 || dut.level !== 8'h20) begin bad++; $display("FAIL mid_resume state=%0d level=%h exp=1/20", state, dut.level); end
        next_frame();
        total++; if (dut.level !== 8'h21 || dut.duty !== 8'h21) begin bad++; $display("FAIL mid_upward level=%h duty=%h exp=21", dut.level, dut.duty); end
        while (mf != 8'd10) tick();
        total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL mid_pwm_before got=%b exp=1", pwm_out); end
        rst = 1'b1;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL mid_rst_state got=%0d exp=0", state); end
        total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL mid_rst_pwm got=%b exp=0", pwm_out); end
        total++; if (amp_en !== 1'b0) begin bad++; $display("FAIL mid_rst_amp got=%b exp=0", amp_en); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_duty_extremes();
        test_overrun();
        test_fade_out();
        test_mid_events();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
